// File: rtl/mem_resp_pkg.sv
// Shared types and address-check helpers for the data-memory responder.
// Used by data_mem_responder and store_buffer.
package mem_resp_pkg;

   // Widest word address a 32-bit byte address can carry. Store-buffer
   // entries use this width so that one entry type serves any ADDR_WIDTH.
   localparam int WORD_ADDR_W = 30;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;

   typedef struct packed {
      logic       valid;
      word_addr_t word_addr;
      logic [31:0] data;
   } sb_entry_t;

   // Where the registered read data comes from.
   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_FWD  = 2'd1,
      RD_RAM  = 2'd2
   } rd_src_e;

   // Byte-offset bits that must be clear for a word access.
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   function automatic logic addr_aligned(input logic [31:0] addr);
      return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
   endfunction

   // In range when every byte-address bit above the word index is zero.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input int unsigned addr_width);
      return (addr >> (addr_width + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/data_mem_responder_store_buffer.sv
// store_buffer: circular FIFO of posted writes with a combinational
// youngest-first associative lookup. Head/tail wrap modulo SB_DEPTH; the
// count tells full from empty. Caller never pops when empty and always
// pops alongside a push when full.
module store_buffer
   import mem_resp_pkg::*;
#(
   parameter  int SB_DEPTH = 4,
   localparam int PTR_W    = $clog2(SB_DEPTH),
   localparam int CNT_W    = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  word_addr_t       push_addr,
   input  logic [31:0]      push_data,
   input  logic             pop,
   input  word_addr_t       lookup_addr,
   output logic             hit,
   output logic [31:0]      hit_data,
   output sb_entry_t        head,
   output logic [CNT_W-1:0] count
);

   sb_entry_t        entries_q [SB_DEPTH];
   sb_entry_t        entries_d [SB_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] lk_idx;

   // Next-state: pop retires the head, push appends at the tail (pop first,
   // so a full buffer can pop and push into the same slot in one cycle).
   always_comb begin
      // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned and infers a latch.
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         entries_d[tail_q] = '{valid: 1'b1, word_addr: push_addr, data: push_data};
         tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State registers; reset discards every pending store.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         entries_q <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   // Walk oldest to youngest so the last (youngest) match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      lk_idx   = head_q;
      for (int k = 0; k < SB_DEPTH; k++) begin
         lk_idx = head_q + PTR_W'(k);
         if (entries_q[lk_idx].valid && entries_q[lk_idx].word_addr == lookup_addr) begin
            hit      = 1'b1;
            hit_data = entries_q[lk_idx].data;
         end
      end
   end

   assign head  = entries_q[head_q];
   assign count = count_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder for the core's data-memory port. Holds the
// single-port RAM, address decode, port arbitration and output registers.
// Optional macro DATA_MEM_STORE_BUF_EN adds a posted-write store buffer with
// read forwarding and idle-cycle drain; without it writes go straight to RAM.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter  int ADDR_WIDTH = 10,
   parameter  int SB_DEPTH   = 4,
   localparam int CNT_W      = $clog2(SB_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_ren,
   input  logic             mem_wen,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_dout,
   output logic [31:0]      mem_din,
   output logic [CNT_W-1:0] sb_count,
   output logic             sb_empty,
   output logic             addr_err
);

   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  in_range;
   logic                  aligned;

   assign word_idx = mem_addr[ADDR_WIDTH+1:2];
   assign in_range = addr_in_range(mem_addr, ADDR_WIDTH);
   assign aligned  = addr_aligned(mem_addr);

   logic [31:0]           ram [2**ADDR_WIDTH];
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [31:0]           ram_wdata;
   logic                  ram_re;
   logic [31:0]           ram_rdata_q;

   logic                  fwd_hit;
   logic [31:0]           fwd_hit_data;

`ifdef DATA_MEM_STORE_BUF_EN
   logic             sb_push;
   logic             sb_pop;
   logic             sb_full;
   sb_entry_t        sb_head;
   logic [CNT_W-1:0] sb_cnt;
   logic             unused_head_bits;

   store_buffer #(.SB_DEPTH(SB_DEPTH)) u_store_buffer (
      .clk         (clk),
      .rst         (rst),
      .push        (sb_push),
      .push_addr   (word_addr_t'(word_idx)),
      .push_data   (mem_dout),
      .pop         (sb_pop),
      .lookup_addr (word_addr_t'(word_idx)),
      .hit         (fwd_hit),
      .hit_data    (fwd_hit_data),
      .head        (sb_head),
      .count       (sb_cnt)
   );

   assign sb_full          = (sb_cnt == CNT_W'(SB_DEPTH));
   assign unused_head_bits = ^{sb_head.valid, sb_head.word_addr[WORD_ADDR_W-1:ADDR_WIDTH]};

   // Arbitration: drain on idle cycles, forced drain when a write meets a
   // full buffer; a read alone keeps the RAM port. Reset suppresses the commit.
   always_comb begin
      sb_push   = mem_wen & in_range;
      sb_pop    = (~mem_ren & ~mem_wen & (sb_cnt != '0)) | (sb_push & sb_full);
      ram_we    = sb_pop & ~rst;
      ram_waddr = sb_head.word_addr[ADDR_WIDTH-1:0];
      ram_wdata = sb_head.data;
      sb_count  = sb_cnt;
      sb_empty  = (sb_cnt == '0);
   end
`else
   // Write-through: in-range writes commit in the write cycle itself.
   always_comb begin
      fwd_hit      = 1'b0;
      fwd_hit_data = '0;
      ram_we       = mem_wen & in_range & ~rst;
      ram_waddr    = word_idx;
      ram_wdata    = mem_dout;
      sb_count     = '0;
      sb_empty     = 1'b1;
   end
`endif

   rd_src_e     rd_src_q, rd_src_d;
   logic [31:0] fwd_data_q, fwd_data_d;
   logic        addr_err_q, addr_err_d;

   // Read-source selection and error pulse; read data holds until next read.
   always_comb begin
      rd_src_d   = rd_src_q;
      fwd_data_d = fwd_data_q;
      if (mem_ren) begin
         if (!in_range) begin
            rd_src_d = RD_ZERO;
         end else if (fwd_hit) begin
            rd_src_d   = RD_FWD;
            fwd_data_d = fwd_hit_data;
         end else begin
            rd_src_d = RD_RAM;
         end
      end
      addr_err_d = (mem_ren | mem_wen) & ~(in_range & aligned);
      ram_re     = mem_ren & in_range & ~fwd_hit;
   end

   // Output-side registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_src_q   <= RD_ZERO;
         fwd_data_q <= '0;
         addr_err_q <= 1'b0;
      end else begin
         rd_src_q   <= rd_src_d;
         fwd_data_q <= fwd_data_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Synchronous RAM port; a same-cycle read returns the pre-write word.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array and its read register carry no reset, so they map onto a plain memory macro; rd_src_q masks stale data.
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
      if (ram_re) begin
         ram_rdata_q <= ram[word_idx];
      end
   end

   // Registered-source read-data mux.
   always_comb begin
      case (rd_src_q)
         RD_FWD:  mem_din = fwd_data_q;
         RD_RAM:  mem_din = ram_rdata_q;
         default: mem_din = '0;
      endcase
   end

   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table of the key sequences, then
// randomized traffic checked against a memory-plus-pending-queue model.
module tb_data_mem_responder;

   localparam int AW    = 10;
   localparam int DEPTH = 4;
`ifdef DATA_MEM_STORE_BUF_EN
   localparam bit SB_ON = 1'b1;
`else
   localparam bit SB_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic [2:0]  sb_count;
   logic        sb_empty;
   logic        addr_err;

   data_mem_responder #(.ADDR_WIDTH(AW), .SB_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_ren  (mem_ren),
      .mem_wen  (mem_wen),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout),
      .mem_din  (mem_din),
      .sb_count (sb_count),
      .sb_empty (sb_empty),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Architectural view: a RAM image plus, when buffering, an ordered list of
   // not-yet-committed stores. Reads see the newest pending store, else RAM.
   typedef struct {
      int unsigned wa;
      logic [31:0] d;
   } pend_t;

   logic [31:0] phys  [1024];
   bit          known [1024];
   pend_t       pend[$];
   logic [31:0] m_din = '0;
   bit          m_din_known = 1'b1;
   bit          m_err = 1'b0;

   task automatic commit_oldest();
      phys[pend[0].wa]  = pend[0].d;
      known[pend[0].wa] = 1'b1;
      void'(pend.pop_front());
   endtask

   task automatic model_step(input bit r, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] d);
      int unsigned wi  = a[11:2];
      bit          inr = (a[31:12] == 20'd0);
      bit          bad = !inr || (a[1:0] != 2'b00);
      bit          found = 1'b0;
      logic [31:0] val = '0;
      if (r) begin
         pend.delete();
         m_din       = '0;
         m_din_known = 1'b1;
         m_err       = 1'b0;
         return;
      end
      m_err = (rd || wr) && bad;
      if (rd) begin
         if (!inr) begin
            m_din       = '0;
            m_din_known = 1'b1;
         end else begin
            foreach (pend[i]) if (pend[i].wa == wi) begin
               found = 1'b1;
               val   = pend[i].d;
            end
            m_din       = found ? val : phys[wi];
            m_din_known = found ? 1'b1 : known[wi];
         end
      end
      if (SB_ON) begin
         if (!rd && !wr && pend.size() > 0) commit_oldest();
         if (wr && inr) begin
            if (pend.size() == DEPTH) commit_oldest();
            pend.push_back('{wa: wi, d: d});
         end
      end else if (wr && inr) begin
         phys[wi]  = d;
         known[wi] = 1'b1;
      end
   endtask

   // One clock: apply inputs, advance the model, sample 1 ns after the edge.
   task automatic drive(input bit r, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      rst      = r;
      mem_ren  = rd;
      mem_wen  = wr;
      mem_addr = a;
      mem_dout = d;
      model_step(r, rd, wr, a, d);
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          r;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_din;
      bit          exp_err;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit r, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_din, input bit exp_err,
                               input int sb_cnt);
      tbl.push_back('{r: r, rd: rd, wr: wr, a: a, d: d, exp_din: exp_din,
                      exp_err: exp_err, exp_cnt: SB_ON ? sb_cnt : 0});
   endfunction

   function automatic void build_table();
      // write then forwarded read
      add(0,0,1, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1);
      add(0,1,0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1);
      add(0,0,0, 32'h0,   32'h0,        32'hDEADBEEF, 0, 0);
      // fill past depth, then drain
      add(0,0,1, 32'h0,  32'd1, 32'hDEADBEEF, 0, 1);
      add(0,0,1, 32'h4,  32'd2, 32'hDEADBEEF, 0, 2);
      add(0,0,1, 32'h8,  32'd3, 32'hDEADBEEF, 0, 3);
      add(0,0,1, 32'hC,  32'd4, 32'hDEADBEEF, 0, 4);
      add(0,0,1, 32'h10, 32'd5, 32'hDEADBEEF, 0, 4);
      add(0,0,0, 32'h0,  32'd0, 32'hDEADBEEF, 0, 3);
      add(0,0,0, 32'h0,  32'd0, 32'hDEADBEEF, 0, 2);
      add(0,0,0, 32'h0,  32'd0, 32'hDEADBEEF, 0, 1);
      add(0,0,0, 32'h0,  32'd0, 32'hDEADBEEF, 0, 0);
      add(0,1,0, 32'h0,  32'd0, 32'd1, 0, 0);
      add(0,1,0, 32'h4,  32'd0, 32'd2, 0, 0);
      add(0,1,0, 32'h8,  32'd0, 32'd3, 0, 0);
      add(0,1,0, 32'hC,  32'd0, 32'd4, 0, 0);
      add(0,1,0, 32'h10, 32'd0, 32'd5, 0, 0);
      // duplicate address, youngest wins
      add(0,0,1, 32'h20, 32'h11, 32'd5,  0, 1);
      add(0,0,1, 32'h20, 32'h22, 32'd5,  0, 2);
      add(0,1,0, 32'h20, 32'h0,  32'h22, 0, 2);
      add(0,0,0, 32'h0,  32'h0,  32'h22, 0, 1);
      add(0,0,0, 32'h0,  32'h0,  32'h22, 0, 0);
      add(0,1,0, 32'h20, 32'h0,  32'h22, 0, 0);
      // address errors
      add(0,0,1, 32'h1000, 32'h55, 32'h22,       1, 0);
      add(0,0,0, 32'h0,    32'h0,  32'h22,       0, 0);
      add(0,1,0, 32'h1000, 32'h0,  32'h0,        1, 0);
      add(0,1,0, 32'h102,  32'h0,  32'hDEADBEEF, 1, 0);
      add(0,0,0, 32'h0,    32'h0,  32'hDEADBEEF, 0, 0);
      // simultaneous read+write sees pre-write data
      add(0,0,1, 32'h80, 32'h77, 32'hDEADBEEF, 0, 1);
      add(0,0,0, 32'h0,  32'h0,  32'hDEADBEEF, 0, 0);
      add(0,1,1, 32'h80, 32'h88, 32'h77,       0, 1);
      add(0,1,0, 32'h80, 32'h0,  32'h88,       0, 1);
      add(0,0,0, 32'h0,  32'h0,  32'h88,       0, 0);
      // read while full keeps buffer; read+write while full force-drains
      add(0,0,1, 32'h0, 32'h31, 32'h88, 0, 1);
      add(0,0,1, 32'h4, 32'h32, 32'h88, 0, 2);
      add(0,0,1, 32'h8, 32'h33, 32'h88, 0, 3);
      add(0,0,1, 32'hC, 32'h34, 32'h88, 0, 4);
      add(0,1,0, 32'h0, 32'h0,  32'h31, 0, 4);
      add(0,1,1, 32'h4, 32'h99, 32'h32, 0, 4);
      add(0,1,0, 32'h4, 32'h0,  32'h99, 0, 4);
      add(0,0,0, 32'h0, 32'h0,  32'h99, 0, 3);
      add(0,0,0, 32'h0, 32'h0,  32'h99, 0, 2);
      add(0,0,0, 32'h0, 32'h0,  32'h99, 0, 1);
      add(0,0,0, 32'h0, 32'h0,  32'h99, 0, 0);
      add(0,1,0, 32'h0, 32'h0,  32'h31, 0, 0);
      add(0,1,0, 32'h4, 32'h0,  32'h99, 0, 0);
      add(0,1,0, 32'hC, 32'h0,  32'h34, 0, 0);
      // reset during a drain cycle discards pending stores
      add(0,0,1, 32'h40, 32'hA, 32'h34, 0, 1);
      add(0,0,0, 32'h0,  32'h0, 32'h34, 0, 0);
      add(0,0,1, 32'h40, 32'hB, 32'h34, 0, 1);
      add(0,0,1, 32'h40, 32'hC, 32'h34, 0, 2);
      add(0,0,1, 32'h40, 32'hD, 32'h34, 0, 3);
      add(1,0,0, 32'h0,  32'h0, 32'h0,  0, 0);
      add(0,1,0, 32'h40, 32'h0, SB_ON ? 32'hA : 32'hD, 0, 0);
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int unsigned word;
      int unsigned k;
      logic [31:0] a;
      bit          r, rd, wr;

      rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
      drive(1, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      check("reset mem_din",  mem_din,          32'h0);
      check("reset sb_count", 32'(sb_count),    32'd0);
      check("reset sb_empty", 32'(sb_empty),    32'd1);
      check("reset addr_err", 32'(addr_err),    32'd0);

      build_table();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         check($sformatf("row%0d mem_din", i),  mem_din,       tbl[i].exp_din);
         check($sformatf("row%0d addr_err", i), 32'(addr_err), 32'(tbl[i].exp_err));
         check($sformatf("row%0d sb_count", i), 32'(sb_count), 32'(tbl[i].exp_cnt));
         check($sformatf("row%0d sb_empty", i), 32'(sb_empty), 32'(tbl[i].exp_cnt == 0));
      end

      // Give every word the random phase touches a known value.
      for (int w = 0; w < 128; w++) begin
         drive(0, 0, 1, 32'(w) << 2, $urandom);
         if (SB_ON) drive(0, 0, 0, 32'h0, 32'h0);
      end
      drive(0, 0, 0, 32'h0, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 199) == 0);
         k = $urandom_range(0, 7);
         rd = (k == 3) || (k == 4) || (k == 7);
         wr = (k == 5) || (k == 6) || (k == 7);
         word = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 127);
         a = 32'(word) << 2;
         k = $urandom_range(0, 15);
         if (k == 0) a = a | (32'h1 << $urandom_range(12, 31));
         if (k == 1) a = a | 32'($urandom_range(1, 3));
         drive(r, rd, wr, a, $urandom);
         if (m_din_known) check($sformatf("rnd%0d mem_din", n), mem_din, m_din);
         check($sformatf("rnd%0d addr_err", n), 32'(addr_err), 32'(m_err));
         check($sformatf("rnd%0d sb_count", n), 32'(sb_count), 32'(pend.size()));
         check($sformatf("rnd%0d sb_empty", n), 32'(sb_empty), 32'(pend.size() == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
